// File: rtl/mux_lut_gate_array.sv
// WIDTH-lane programmable 2-input gate: each lane picks one bit of a 4-bit truth table by {a, b_eff}.
// Results are queued in a DEPTH-entry FIFO with valid/ready on both sides.
module mux_lut_gate_array #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_tt,
    input  logic             cfg_acc,
    input  logic             acc_clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] txn_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic [3:0]       tt_q;
    logic             acc_mode_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] b_eff, r;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] txn_q, txn_d;
    logic             accept, pop;

    // Ready depends only on registered occupancy: a full buffer never accepts, even while popping.
    assign in_ready  = count_q < CW'(DEPTH);
    assign out_valid = count_q != '0;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign txn_count = txn_q;

    always_comb begin
        b_eff = acc_mode_q ? acc_q : b;
        r     = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            r[i] = tt_q[{a[i], b_eff[i]}];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        txn_d    = txn_q;
        acc_d    = acc_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            txn_d    = txn_q + CNT_W'(1);
            if (acc_mode_q) begin
                acc_d = r;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Clear wins over an accumulate update at the same edge.
        if (acc_clr) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tt_q       <= 4'b0110;
            acc_mode_q <= 1'b0;
            acc_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            txn_q      <= '0;
        end else begin
            if (cfg_we) begin
                tt_q       <= cfg_tt;
                acc_mode_q <= cfg_acc;
            end
            acc_q    <= acc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            txn_q    <= txn_d;
        end
    end

    // Storage needs no reset: out_data is gated by out_valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= r;
        end
    end

endmodule

// File: tb/tb_mux_lut_gate_array.sv
// Scoreboard bench for mux_lut_gate_array: expected results are queued at accept and
// compared when the DUT pops its buffer head.
module tb_mux_lut_gate_array;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_we = 1'b0;
    logic [3:0]       cfg_tt = 4'b0110;
    logic             cfg_acc = 1'b0;
    logic             acc_clr = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] txn_count;

    int               checks = 0;
    int               passes = 0;
    logic [WIDTH-1:0] sb [$];
    logic [WIDTH-1:0] mon_exp;
    logic [CNT_W-1:0] exp_txn = '0;

    mux_lut_gate_array #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_tt   (cfg_tt),
        .cfg_acc  (cfg_acc),
        .acc_clr  (acc_clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    // Output monitor: every pop is checked against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_output: got %h, required no output", out_data);
            end else begin
                mon_exp = sb.pop_front();
                if (out_data !== mon_exp)
                    $display("FAIL out_data: got %h, required %h", out_data, mon_exp);
                else
                    passes++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [3:0] tt, input logic acc);
        cfg_tt  = tt;
        cfg_acc = acc;
        cfg_we  = 1'b1;
        tick();
        cfg_we  = 1'b0;
    endtask

    task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic [WIDTH-1:0] ev);
        bit ok = 1'b0;
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
        end else begin
            sb.push_back(ev);
            exp_txn++;
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 100; n++) begin
            tick();
            if (sb.size() == 0 && !out_valid) break;
        end
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0)
            $display("FAIL drain: %0d results pending, out_valid %b, required 0 and 0",
                     sb.size(), out_valid);
        else
            passes++;
    endtask

    task automatic check_txn(input string name);
        checks++;
        if (txn_count !== exp_txn)
            $display("FAIL %s: txn_count %0d, required %0d", name, txn_count, exp_txn);
        else
            passes++;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, required 0", out_valid);
        else passes++;
        checks++;
        if (out_data !== 8'h00) $display("FAIL reset_out_data: got %h, required 00", out_data);
        else passes++;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        else passes++;
        check_txn("reset_txn");
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_xor();
        out_ready = 1'b1;
        send(8'hF0, 8'hAA, 8'h5A);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A)
            $display("FAIL xor_latency: valid %b data %h, required 1 5a", out_valid, out_data);
        else
            passes++;
        check_txn("xor_txn");
        drain();
    endtask

    task automatic test_gates();
        cfg(4'b1000, 1'b0);
        send(8'hCC, 8'hAA, 8'h88);
        cfg(4'b0111, 1'b0);
        send(8'hCC, 8'hAA, 8'h77);
        drain();
    endtask

    task automatic test_cfg_same_cycle();
        cfg(4'b0110, 1'b0);
        checks++;
        if (in_ready !== 1'b1) $display("FAIL cfg_same_ready: got %b, required 1", in_ready);
        else passes++;
        cfg_tt   = 4'b1110;
        cfg_acc  = 1'b0;
        cfg_we   = 1'b1;
        in_valid = 1'b1;
        a        = 8'hF0;
        b        = 8'hAA;
        sb.push_back(8'h5A);
        exp_txn++;
        tick();
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        send(8'hF0, 8'hAA, 8'hFA);
        drain();
        check_txn("cfg_same_txn");
    endtask

    task automatic test_accumulate();
        cfg(4'b0110, 1'b1);
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        send(8'h01, 8'hFF, 8'h01);
        send(8'h02, 8'hFF, 8'h03);
        send(8'h04, 8'hFF, 8'h07);
        drain();
        acc_clr = 1'b1;
        send(8'h08, 8'hFF, 8'h0F);
        acc_clr = 1'b0;
        send(8'h10, 8'hFF, 8'h10);
        drain();
        cfg(4'b0110, 1'b0);
    endtask

    task automatic test_back_to_back();
        bit ok = 1'b0;
        out_ready = 1'b0;
        send(8'h11, 8'h0F, 8'h1E);
        send(8'h22, 8'h0F, 8'h2D);
        in_valid = 1'b1;
        a        = 8'h33;
        b        = 8'h0F;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) $display("FAIL full_in_ready: got %b, required 0", in_ready);
            else passes++;
        end
        checks++;
        if (out_data !== 8'h1E) $display("FAIL held_head: got %h, required 1e", out_data);
        else passes++;
        check_txn("full_txn");
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) $display("FAIL full_pop_ready: got %b, required 0", in_ready);
        else passes++;
        tick();
        check_txn("full_pop_no_accept");
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            $display("FAIL third_ready: in_ready %b, required 1", in_ready);
        end else begin
            passes++;
            sb.push_back(8'h3C);
            exp_txn++;
        end
        tick();
        in_valid = 1'b0;
        drain();
        check_txn("b2b_txn");
    endtask

    task automatic test_reset_mid();
        cfg(4'b1000, 1'b0);
        out_ready = 1'b0;
        send(8'hFF, 8'h0F, 8'h0F);
        send(8'hF0, 8'hFF, 8'hF0);
        rst = 1'b1;
        sb.delete();
        exp_txn = '0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL midrst_valid: got %b, required 0", out_valid);
        else passes++;
        check_txn("midrst_txn");
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        send(8'hF0, 8'hAA, 8'h5A);
        drain();
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] av;
        for (int i = 0; i < 20; i++) begin
            av = WIDTH'(i * 7 + 3);
            send(av, 8'h0F, av ^ 8'h0F);
        end
        drain();
        check_txn("wrap_txn");
    endtask

    initial begin
        test_reset();
        test_xor();
        test_gates();
        test_cfg_same_cycle();
        test_accumulate();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
